// File: rtl/clic_ctrl.sv
// Core-local interrupt controller: synchronised interrupt inputs, per-id pending/enable/attr/ctl
// registers on a single-cycle slave bus, and a registered level/priority arbiter feeding the core.
module clic_ctrl #(
  parameter int unsigned NUM_IRQ     = 64,
  parameter int unsigned CTL_BITS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clic_valid,
  input  logic [31:0]        clic_addr,
  input  logic [31:0]        clic_wdata,
  input  logic [3:0]         clic_wstrb,
  output logic [31:0]        clic_rdata,
  output logic               clic_ready,
  input  logic [NUM_IRQ-1:0] clic_irpt,
  input  logic               clic_claim,
  input  logic [11:0]        clic_claim_id,
  output logic               clic_meip,
  output logic [11:0]        clic_meid,
  output logic [7:0]         clic_mlevel,
  output logic               clic_shv
);

  localparam int unsigned IDX_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [7:0]  CTL_LOW  = 8'((1 << (8 - CTL_BITS)) - 1);
  localparam logic [7:0]  CTL_MASK = ~CTL_LOW;
  localparam logic [31:0] INT_BASE = 32'h0000_1000;

  // Input synchroniser chain (bypassed when the lines are already synchronous)
  logic [NUM_IRQ-1:0] irq_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign irq_s = clic_irpt;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= clic_irpt;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign irq_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [NUM_IRQ-1:0] irq_p_q;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic [NUM_IRQ-1:0] ie_q;
  logic [NUM_IRQ-1:0] hv_q;
  logic [1:0]         trig_q [NUM_IRQ];
  logic [7:0]         ctl_q  [NUM_IRQ];
  logic [3:0]         nlbits_q;
  logic [7:0]         thresh_q;

  logic               ready_q;
  logic [31:0]        rdata_q;
  logic               meip_q;
  logic [11:0]        meid_q;
  logic [7:0]         mlevel_q;
  logic               mshv_q;

  // Address decode
  logic [31:0]      off;
  logic             int_hit;
  logic [IDX_W-1:0] idx;
  logic             wr_en;

  assign off     = clic_addr - INT_BASE;
  assign int_hit = (clic_addr >= INT_BASE) && (off[1:0] == 2'b00) && (off[31:2] < 30'(NUM_IRQ));
  assign idx     = off[IDX_W+1:2];
  assign wr_en   = clic_valid && (clic_wstrb != 4'b0000);

  logic [NUM_IRQ-1:0] int_sel;
  logic [NUM_IRQ-1:0] claim_sel;
  logic [NUM_IRQ-1:0] edge_det;

  always_comb begin
    int_sel   = '0;
    claim_sel = '0;
    edge_det  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      int_sel[i]   = wr_en && int_hit && (idx == IDX_W'(i));
      claim_sel[i] = clic_claim && (clic_claim_id == 12'(i)) && (i != 0);
      edge_det[i]  = trig_q[i][1] ? (~irq_s[i] & irq_p_q[i]) : (irq_s[i] & ~irq_p_q[i]);
    end
  end

  // Pending next state: level ids track the line; edge ids apply write < claim < edge
  always_comb begin
    ip_d = ip_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!trig_q[i][0]) begin
        ip_d[i] = irq_s[i] ^ trig_q[i][1];
      end else begin
        if (int_sel[i] && clic_wstrb[0]) ip_d[i] = clic_wdata[0];
        if (claim_sel[i])                ip_d[i] = 1'b0;
        if (edge_det[i])                 ip_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_p_q  <= '0;
      ip_q     <= '0;
      ie_q     <= '0;
      hv_q     <= '0;
      nlbits_q <= '0;
      thresh_q <= '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        trig_q[i] <= '0;
        ctl_q[i]  <= '0;
      end
    end else begin
      irq_p_q <= irq_s;
      ip_q    <= ip_d;
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (int_sel[i]) begin
          if (clic_wstrb[1]) ie_q[i] <= clic_wdata[8];
          if (clic_wstrb[2]) begin
            hv_q[i]   <= clic_wdata[16];
            trig_q[i] <= clic_wdata[18:17];
          end
          if (clic_wstrb[3]) ctl_q[i] <= clic_wdata[31:24] & CTL_MASK;
        end
      end
      if (wr_en && clic_wstrb[0] && (clic_addr == 32'h0000_0000)) begin
        nlbits_q <= (clic_wdata[4:1] > 4'd8) ? 4'd8 : clic_wdata[4:1];
      end
      if (wr_en && clic_wstrb[0] && (clic_addr == 32'h0000_0008)) begin
        thresh_q <= clic_wdata[7:0];
      end
    end
  end

  // Read mux returns pre-write contents
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    if (clic_addr == 32'h0000_0000) begin
      rd_data = {27'b0, nlbits_q, 1'b0};
    end else if (clic_addr == 32'h0000_0004) begin
      rd_data = {7'b0, 4'(CTL_BITS), 8'b0, 13'(NUM_IRQ)};
    end else if (clic_addr == 32'h0000_0008) begin
      rd_data = {24'b0, thresh_q};
    end else if (int_hit) begin
      rd_data = {ctl_q[idx] | CTL_LOW, 5'b0, trig_q[idx], hv_q[idx],
                 7'b0, ie_q[idx], 7'b0, ip_q[idx]};
    end
  end

  // Sort key: {level, prio} split of the effective control value at nlbits n
  function automatic logic [15:0] arb_key(input logic [7:0] ctl, input logic [3:0] n);
    logic [7:0] eff;
    logic [7:0] lvl;
    logic [7:0] pri;
    eff = ctl | CTL_LOW;
    lvl = eff | (8'hFF >> n);
    pri = (eff << n) | ~(8'hFF << n);
    return {lvl, pri};
  endfunction

  logic        win_found;
  logic [15:0] win_key;
  logic [15:0] cand_key;
  logic [11:0] win_id;
  logic        win_shv;
  logic        meip_d;

  // Strict compare in ascending id order keeps the lowest id on ties
  always_comb begin
    win_found = 1'b0;
    win_key   = '0;
    cand_key  = '0;
    win_id    = '0;
    win_shv   = 1'b0;
    for (int i = 1; i < NUM_IRQ; i++) begin
      if (ip_q[i] && ie_q[i]) begin
        cand_key = arb_key(ctl_q[i], nlbits_q);
        if (!win_found || (cand_key > win_key)) begin
          win_found = 1'b1;
          win_key   = cand_key;
          win_id    = 12'(i);
          win_shv   = hv_q[i];
        end
      end
    end
    meip_d = win_found && (win_key[15:8] > thresh_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      meip_q   <= 1'b0;
      meid_q   <= '0;
      mlevel_q <= '0;
      mshv_q   <= 1'b0;
    end else begin
      ready_q  <= clic_valid;
      rdata_q  <= (clic_valid && (clic_wstrb == 4'b0000)) ? rd_data : '0;
      meip_q   <= meip_d;
      meid_q   <= meip_d ? win_id : '0;
      mlevel_q <= meip_d ? win_key[15:8] : '0;
      mshv_q   <= meip_d && win_shv;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{clic_wdata[15:9], clic_wdata[23:19]};

  assign clic_ready  = ready_q;
  assign clic_rdata  = rdata_q;
  assign clic_meip   = meip_q;
  assign clic_meid   = meid_q;
  assign clic_mlevel = mlevel_q;
  assign clic_shv    = mshv_q;

endmodule

// File: tb/tb_clic_ctrl.sv
// Directed bench for clic_ctrl at default parameters (64 ids, 4 ctl bits, 2 sync stages).
module tb_clic_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        clic_valid;
  logic [31:0] clic_addr;
  logic [31:0] clic_wdata;
  logic [3:0]  clic_wstrb;
  logic [31:0] clic_rdata;
  logic        clic_ready;
  logic [63:0] clic_irpt;
  logic        clic_claim;
  logic [11:0] clic_claim_id;
  logic        clic_meip;
  logic [11:0] clic_meid;
  logic [7:0]  clic_mlevel;
  logic        clic_shv;

  int n_cmp = 0;
  int n_err = 0;

  clic_ctrl #(.NUM_IRQ(64), .CTL_BITS(4), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .clic_valid    (clic_valid),
    .clic_addr     (clic_addr),
    .clic_wdata    (clic_wdata),
    .clic_wstrb    (clic_wstrb),
    .clic_rdata    (clic_rdata),
    .clic_ready    (clic_ready),
    .clic_irpt     (clic_irpt),
    .clic_claim    (clic_claim),
    .clic_claim_id (clic_claim_id),
    .clic_meip     (clic_meip),
    .clic_meid     (clic_meid),
    .clic_mlevel   (clic_mlevel),
    .clic_shv      (clic_shv)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_read(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    clic_valid = 1'b1;
    clic_addr  = addr;
    clic_wdata = '0;
    clic_wstrb = 4'h0;
    tick();
    clic_valid = 1'b0;
    check_eq({tag, "_rdy"}, 32'(clic_ready), 32'd1);
    check_eq(tag, clic_rdata, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    clic_valid = 1'b1;
    clic_addr  = addr;
    clic_wdata = data;
    clic_wstrb = strb;
    tick();
    clic_valid = 1'b0;
    clic_wstrb = 4'h0;
  endtask

  task automatic check_out(input string tag, input logic meip, input logic [11:0] id,
                           input logic [7:0] lvl, input logic shv);
    check_eq({tag, "_meip"},   32'(clic_meip),   32'(meip));
    check_eq({tag, "_meid"},   32'(clic_meid),   32'(id));
    check_eq({tag, "_mlevel"}, 32'(clic_mlevel), 32'(lvl));
    check_eq({tag, "_shv"},    32'(clic_shv),    32'(shv));
  endtask

  initial begin
    reset         = 1'b1;
    clic_valid    = 1'b0;
    clic_addr     = '0;
    clic_wdata    = '0;
    clic_wstrb    = '0;
    clic_irpt     = '0;
    clic_claim    = 1'b0;
    clic_claim_id = '0;

    ticks(2);
    check_eq("rst_ready", 32'(clic_ready), 32'd0);
    check_eq("rst_rdata", clic_rdata, 32'd0);
    check_out("rst", 1'b0, 12'd0, 8'd0, 1'b0);
    reset = 1'b0;
    tick();

    // Identification and reset contents
    bus_read(32'h0004, "info", 32'h0080_0040);
    bus_read(32'h1014, "int5_rst", 32'h0F00_0000);
    bus_read(32'h0000, "cfg_rst", 32'h0000_0000);
    bus_read(32'h0008, "thr_rst", 32'h0000_0000);

    // Unmapped and out-of-range accesses
    bus_read(32'h0800, "unmapped", 32'h0000_0000);
    tick();
    check_eq("ready_drop", 32'(clic_ready), 32'd0);
    bus_write(32'h0800, 32'hFFFF_FFFF, 4'hF);
    bus_write(32'h1100, 32'hFF03_0101, 4'hF);
    bus_read(32'h0000, "cfg_after_unm", 32'h0000_0000);
    bus_read(32'h0008, "thr_after_unm", 32'h0000_0000);
    bus_read(32'h1000, "int0_no_alias", 32'h0F00_0000);
    bus_read(32'h1100, "int64_oor", 32'h0000_0000);

    // Back-to-back reads
    clic_valid = 1'b1;
    clic_addr  = 32'h0004;
    tick();
    check_eq("b2b_rd0", clic_rdata, 32'h0080_0040);
    clic_addr = 32'h1014;
    tick();
    check_eq("b2b_rdy1", 32'(clic_ready), 32'd1);
    check_eq("b2b_rd1", clic_rdata, 32'h0F00_0000);
    clic_valid = 1'b0;
    tick();
    check_eq("b2b_end", 32'(clic_ready), 32'd0);

    // Level-mode id 3: latency SYNC_STAGES+2 both ways
    bus_write(32'h100C, 32'h8000_0100, 4'hF);
    bus_read(32'h100C, "int3_rd", 32'h8F00_0100);
    clic_irpt[3] = 1'b1;
    ticks(3);
    check_eq("lvl_rise_early", 32'(clic_meip), 32'd0);
    tick();
    check_out("lvl_rise", 1'b1, 12'd3, 8'hFF, 1'b0);
    clic_irpt[3] = 1'b0;
    ticks(3);
    check_eq("lvl_fall_early", 32'(clic_meip), 32'd1);
    tick();
    check_out("lvl_fall", 1'b0, 12'd0, 8'd0, 1'b0);

    // nlbits clamp, then arbitration at nlbits=2
    bus_write(32'h0000, 32'h0000_001E, 4'h1);
    bus_read(32'h0000, "nlbits_clamp", 32'h0000_0010);
    bus_write(32'h0000, 32'h0000_0004, 4'h1);
    bus_read(32'h0000, "nlbits2", 32'h0000_0004);
    bus_write(32'h1010, 32'h4000_0100, 4'hF);
    bus_write(32'h1024, 32'h8000_0100, 4'hF);
    clic_irpt[4] = 1'b1;
    clic_irpt[9] = 1'b1;
    ticks(4);
    check_out("arb_level", 1'b1, 12'd9, 8'hBF, 1'b0);
    bus_write(32'h1010, 32'h9000_0000, 4'h8);
    tick();
    check_out("arb_prio", 1'b1, 12'd4, 8'hBF, 1'b0);
    bus_write(32'h1010, 32'h8000_0000, 4'h8);
    tick();
    check_out("arb_tie", 1'b1, 12'd4, 8'hBF, 1'b0);
    bus_write(32'h1010, 32'h4000_0000, 4'h8);
    tick();
    check_out("arb_back", 1'b1, 12'd9, 8'hBF, 1'b0);
    bus_write(32'h0008, 32'h0000_00BF, 4'h1);
    tick();
    check_out("thr_bf", 1'b0, 12'd0, 8'd0, 1'b0);
    bus_write(32'h0008, 32'h0000_00BE, 4'h1);
    tick();
    check_out("thr_be", 1'b1, 12'd9, 8'hBF, 1'b0);
    bus_read(32'h0008, "thr_rd", 32'h0000_00BE);
    bus_write(32'h0008, 32'h0000_0000, 4'h1);
    clic_irpt[4] = 1'b0;
    clic_irpt[9] = 1'b0;
    ticks(4);
    check_eq("arb_idle", 32'(clic_meip), 32'd0);

    // Rising-edge id 7 with shv
    bus_write(32'h101C, 32'h0003_0100, 4'hF);
    bus_read(32'h101C, "int7_cfg", 32'h0F03_0100);
    clic_irpt[7] = 1'b1;
    tick();
    clic_irpt[7] = 1'b0;
    ticks(3);
    check_out("edge_set", 1'b1, 12'd7, 8'h3F, 1'b1);
    ticks(3);
    check_eq("edge_hold", 32'(clic_meip), 32'd1);
    bus_read(32'h101C, "int7_ip", 32'h0F03_0101);

    // Out-of-range claim has no effect, real claim clears
    clic_claim    = 1'b1;
    clic_claim_id = 12'd71;
    tick();
    clic_claim = 1'b0;
    tick();
    check_out("claim_oor", 1'b1, 12'd7, 8'h3F, 1'b1);
    clic_claim    = 1'b1;
    clic_claim_id = 12'd7;
    tick();
    clic_claim = 1'b0;
    check_eq("claim_stale", 32'(clic_meip), 32'd1);
    tick();
    check_out("claim_clr", 1'b0, 12'd0, 8'd0, 1'b0);
    bus_read(32'h101C, "int7_claimed", 32'h0F03_0100);

    // Claim coinciding with a new edge keeps ip set
    clic_irpt[7] = 1'b1;
    tick();
    clic_irpt[7] = 1'b0;
    ticks(3);
    check_eq("race_setup", 32'(clic_meip), 32'd1);
    clic_irpt[7] = 1'b1;
    tick();
    clic_irpt[7] = 1'b0;
    tick();
    clic_claim    = 1'b1;
    clic_claim_id = 12'd7;
    tick();
    clic_claim = 1'b0;
    tick();
    check_eq("race_meip1", 32'(clic_meip), 32'd1);
    tick();
    check_eq("race_meip2", 32'(clic_meip), 32'd1);
    bus_read(32'h101C, "race_ip", 32'h0F03_0101);

    // Bus write of ip=0 on an edge id, byte lane 0 only
    bus_write(32'h101C, 32'h0000_0000, 4'h1);
    tick();
    check_eq("ip_wr0", 32'(clic_meip), 32'd0);
    bus_read(32'h101C, "ip_wr0_rd", 32'h0F03_0100);

    // Reset during a response
    clic_valid = 1'b1;
    clic_addr  = 32'h0004;
    tick();
    check_eq("mid_rdy", 32'(clic_ready), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_rdy", 32'(clic_ready), 32'd0);
    check_eq("mid_rst_rdata", clic_rdata, 32'd0);
    clic_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bus_read(32'h101C, "post_rst_int7", 32'h0F00_0000);
    bus_read(32'h0000, "post_rst_cfg", 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
